zigzag_scan_gen: RTL

Parametrised, back-pressure-aware 2-D coordinate sequencer for COL x ROW coefficient blocks, with selectable scan order. Generalises the fixed 8x8 zigzag scanner in the following ways:
- rectangular blocks
- multiple scan modes
- valid/ready output handshake
- linear address output
- last-beat flag
- abort
Sits between the block buffer (RAM read address) and the entropy/quantiser stage.

---
 rtl/zigzag_pkg.sv | 22 ++
 rtl/zigzag_step.sv | 78 +++++++
 rtl/zigzag_scan_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/zigzag_pkg.sv
// Shared types for the zigzag/raster/column coordinate sequencer.
// Mode 3 is SERPENTINE when ZIGZAG_SERPENTINE_EN is defined, otherwise ZIGZAG.
package zigzag_pkg;

  typedef enum logic [1:0] {
    SCAN_ZIGZAG = 2'd0,
    SCAN_RASTER = 2'd1,
    SCAN_COLUMN = 2'd2,
    SCAN_SERP   = 2'd3
  } scan_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zigzag_step.sv
// Combinational next-coordinate generator for one scan step.
// The serpentine branch exists only when ZIGZAG_SERPENTINE_EN is defined.
module zigzag_step
  import zigzag_pkg::*;
#(
  parameter int COL = 8,
  parameter int ROW = 8,
  parameter int XW  = clog2_min1(COL),
  parameter int YW  = clog2_min1(ROW)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  scan_mode_t    mode,
  output logic [XW-1:0] x_next,
  output logic [YW-1:0] y_next
);

  localparam logic [XW-1:0] X_MAX = XW'(COL - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROW - 1);

  always_comb begin
    x_next = x;
    y_next = y;
    case (mode)
      SCAN_RASTER: begin
        if (x == X_MAX) begin
          x_next = '0;
          y_next = y + 1'b1;
        end else begin
          x_next = x + 1'b1;
        end
      end
      SCAN_COLUMN: begin
        if (y == Y_MAX) begin
          y_next = '0;
          x_next = x + 1'b1;
        end else begin
          y_next = y + 1'b1;
        end
      end
`ifdef ZIGZAG_SERPENTINE_EN
      SCAN_SERP: begin
        // Even rows run left-to-right, odd rows right-to-left.
        if (!y[0]) begin
          if (x == X_MAX) y_next = y + 1'b1;
          else            x_next = x + 1'b1;
        end else begin
          if (x == '0) y_next = y + 1'b1;
          else         x_next = x - 1'b1;
        end
      end
`endif
      default: begin
        // Parity of x+y picks the diagonal direction: up-right or down-left.
        if ((x[0] ^ y[0]) == 1'b0) begin
          if (x == X_MAX) begin
            y_next = y + 1'b1;
          end else if (y == '0) begin
            x_next = x + 1'b1;
          end else begin
            x_next = x + 1'b1;
            y_next = y - 1'b1;
          end
        end else begin
          if (y == Y_MAX) begin
            x_next = x + 1'b1;
          end else if (x == '0) begin
            y_next = y + 1'b1;
          end else begin
            x_next = x - 1'b1;
            y_next = y + 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/zigzag_scan_gen.sv
// COL x ROW block coordinate sequencer with valid/ready output, abort and back-to-back restart.
// Optional mode 3 SERPENTINE order is enabled by ZIGZAG_SERPENTINE_EN.
module zigzag_scan_gen
  import zigzag_pkg::*;
#(
  parameter int  COL = 8,
  parameter int  ROW = 8,
  localparam int XW  = clog2_min1(COL),
  localparam int YW  = clog2_min1(ROW),
  localparam int IW  = clog2_min1(COL * ROW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          abort,
  input  logic          ready,
  output logic          valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [IW-1:0] idx,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [IW-1:0] LAST_BEAT = IW'(COL * ROW - 1);

  state_t        state_reg;
  scan_mode_t    mode_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [IW-1:0] beat_reg;
  logic          valid_reg;
  logic          done_reg;
  logic [XW-1:0] x_step;
  logic [YW-1:0] y_step;
  logic          accept;

  zigzag_step #(
    .COL (COL),
    .ROW (ROW),
    .XW  (XW),
    .YW  (YW)
  ) u_step (
    .x      (x_reg),
    .y      (y_reg),
    .mode   (mode_reg),
    .x_next (x_step),
    .y_next (y_step)
  );

  assign accept = valid_reg && ready;
  assign valid  = valid_reg;
  assign x      = x_reg;
  assign y      = y_reg;
  assign idx    = IW'(y_reg * COL + x_reg);
  assign last   = valid_reg && (beat_reg == LAST_BEAT);
  assign busy   = (state_reg == SCAN);
  assign done   = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= SCAN_ZIGZAG;
      x_reg     <= '0;
      y_reg     <= '0;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SCAN;
            mode_reg  <= scan_mode_t'(mode);
            valid_reg <= 1'b1;
            x_reg     <= '0;
            y_reg     <= '0;
            beat_reg  <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            beat_reg  <= '0;
          end else if (accept) begin
            if (last) begin
              // A start at the final handshake chains the next block with no bubble.
              x_reg    <= '0;
              y_reg    <= '0;
              beat_reg <= '0;
              done_reg <= 1'b1;
              if (start) begin
                mode_reg <= scan_mode_t'(mode);
              end else begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
              end
            end else begin
              x_reg    <= x_step;
              y_reg    <= y_step;
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
